// File: rtl/sseg_pkg.sv
// Shared definitions for the 7-segment capture block: glyph encoding, glyph
// table, FSM state encoding and one-hot-low digit-enable helpers.
package sseg_pkg;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

    // Active-low a..g patterns for hex digits 0..F, identical to hex_to_sseg.
    localparam logic [6:0] GLYPH_TBL [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    function automatic logic [6:0] hex_to_sseg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h01;
            4'h1: pat = 7'h4F;
            4'h2: pat = 7'h12;
            4'h3: pat = 7'h06;
            4'h4: pat = 7'h4C;
            4'h5: pat = 7'h24;
            4'h6: pat = 7'h20;
            4'h7: pat = 7'h0F;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h04;
            4'hA: pat = 7'h08;
            4'hB: pat = 7'h60;
            4'hC: pat = 7'h31;
            4'hD: pat = 7'h42;
            4'hE: pat = 7'h30;
            default: pat = 7'h38;
        endcase
        return pat;
    endfunction

    function automatic logic onehot_low(input logic [3:0] an);
        return (an == 4'b1110) || (an == 4'b1101) ||
               (an == 4'b1011) || (an == 4'b0111);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] an);
        logic [1:0] idx;
        case (an)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/sseg_to_hex.sv
// Combinational reverse lookup of a 7-bit active-low segment pattern to its hex digit.
module sseg_to_hex
    import sseg_pkg::*;
(
    input  logic [6:0] pat,
    output logic       match_c,
    output logic [3:0] nibble_c
);

    always_comb begin
        match_c  = 1'b0;
        nibble_c = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (pat == hex_to_sseg(4'(i))) begin
                match_c  = 1'b1;
                nibble_c = 4'(i);
            end
        end
    end

endmodule

// File: rtl/sseg_capture.sv
// Recovers the four hex digits shown by a multiplexed 7-segment driver by
// sampling its anode/segment lines and capturing each digit once it is stable.
module sseg_capture
    import sseg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [7:0]  sseg,
    output logic [15:0] hex_digits,
    output logic [3:0]  dp_bits,
    output logic        frame_valid,
    output logic        decode_err,
    output logic        stale
);

    localparam int unsigned CW = 8;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    logic [11:0]   sync1, sync2, prev;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tmo;
    logic [15:0]   slots;
    logic [3:0]    slot_dp;
    logic [3:0]    seen;

    logic          onehot_c, changed_c, cap_c, match_c;
    logic [3:0]    nibble_c;
    logic [1:0]    idx_c;
    logic [TW-1:0] tmo_next_c;

    // prev always holds the last sample the FSM consumed, i.e. the stable pattern at capture.
    assign onehot_c  = onehot_low(sync2[11:8]);
    assign changed_c = (sync2 != prev);
    assign cap_c     = (state == SETTLE) && (cnt == CW'(STABLE_CYCLES));
    assign idx_c     = low_index(prev[11:8]);

    sseg_to_hex u_dec (
        .pat      (prev[6:0]),
        .match_c  (match_c),
        .nibble_c (nibble_c)
    );

    always_comb begin
        tmo_next_c = tmo;
        if (cap_c && match_c) tmo_next_c = '0;
        else if (tmo != TMAX) tmo_next_c = tmo + TW'(1);
    end

    // Two-flop synchronizer plus previous-sample register; blank (all ones) at reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= {an, sseg};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Stability FSM: counts consecutive identical samples of a single-digit pattern.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT;
            cnt   <= '0;
        end else begin
            case (state)
                WAIT: begin
                    if (onehot_c) begin
                        state <= SETTLE;
                        cnt   <= CW'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                SETTLE, HELD: begin
                    if (changed_c) begin
                        state <= onehot_c ? SETTLE : WAIT;
                        cnt   <= onehot_c ? CW'(1) : '0;
                    end else if (cap_c) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (state == SETTLE) begin
                        cnt   <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= WAIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Slot capture, frame assembly and timeout tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            slots       <= '0;
            slot_dp     <= '0;
            seen        <= '0;
            tmo         <= '0;
            hex_digits  <= '0;
            dp_bits     <= '0;
            frame_valid <= 1'b0;
            decode_err  <= 1'b0;
            stale       <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            decode_err  <= 1'b0;
            tmo         <= tmo_next_c;
            stale       <= (tmo_next_c == TMAX);
            if (seen == 4'hF) begin
                hex_digits  <= slots;
                dp_bits     <= slot_dp;
                frame_valid <= 1'b1;
                seen        <= '0;
            end
            if (cap_c) begin
                if (match_c) begin
                    slots[{idx_c, 2'b00} +: 4] <= nibble_c;
                    slot_dp[idx_c]             <= ~prev[7];
                    seen[idx_c]                <= 1'b1;
                end else begin
                    decode_err                 <= 1'b1;
                    seen[idx_c]                <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sseg_capture.sv
// Self-checking bench for sseg_capture: directed scenarios plus randomized
// digit streams checked against a run-length reference model.
module tb_sseg_capture;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 300;

    logic        clk;
    logic        reset;
    logic [3:0]  an_r;
    logic [7:0]  sseg_r;
    logic [15:0] hex_digits;
    logic [3:0]  dp_bits;
    logic        frame_valid;
    logic        decode_err;
    logic        stale;

    int tests_run = 0;
    int fails     = 0;
    int fv_total  = 0;
    int de_total  = 0;
    logic [19:0] frames_q[$];

    logic [6:0] glyph [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    sseg_capture #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .an          (an_r),
        .sseg        (sseg_r),
        .hex_digits  (hex_digits),
        .dp_bits     (dp_bits),
        .frame_valid (frame_valid),
        .decode_err  (decode_err),
        .stale       (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (frame_valid) begin
                fv_total++;
                frames_q.push_back({dp_bits, hex_digits});
            end
            if (decode_err) de_total++;
        end
    end

    function automatic logic [7:0] seg(input int d, input bit dp);
        return {~dp, glyph[d]};
    endfunction

    function automatic logic [3:0] an_of(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << i);
    endfunction

    task automatic show(input logic [3:0] a, input logic [7:0] s, input int n);
        an_r   = a;
        sseg_r = s;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        an_r   = 4'hF;
        sseg_r = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (hex_digits !== 16'h0000) begin fails++; $display("FAIL reset_hex: got %h want 0000", hex_digits); end
        tests_run++;
        if (dp_bits !== 4'h0) begin fails++; $display("FAIL reset_dp: got %b want 0000", dp_bits); end
        tests_run++;
        if (frame_valid !== 1'b0) begin fails++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
        tests_run++;
        if (decode_err !== 1'b0) begin fails++; $display("FAIL reset_de: got %b want 0", decode_err); end
        tests_run++;
        if (stale !== 1'b0) begin fails++; $display("FAIL reset_stale: got %b want 0", stale); end
    endtask

    task automatic test_basic_frame();
        int fv0;
        do_reset();
        fv0 = fv_total;
        for (int i = 0; i < 4; i++) show(an_of(i), seg(i + 1, 1'b0), 10);
        show(4'hF, 8'hFF, 10);
        tests_run++;
        if (fv_total - fv0 !== 1) begin fails++; $display("FAIL basic_count: got %0d frames want 1", fv_total - fv0); end
        tests_run++;
        if (hex_digits !== 16'h4321) begin fails++; $display("FAIL basic_hex: got %h want 4321", hex_digits); end
        tests_run++;
        if (dp_bits !== 4'h0) begin fails++; $display("FAIL basic_dp: got %b want 0000", dp_bits); end
    endtask

    task automatic test_latency();
        int lat;
        bit got;
        do_reset();
        show(an_of(0), seg(5, 1'b0), 10);
        show(an_of(1), seg(6, 1'b0), 10);
        show(an_of(2), seg(9, 1'b0), 10);
        an_r   = an_of(3);
        sseg_r = seg(7, 1'b0);
        @(posedge clk);
        #1;
        lat = 0;
        got = 1'b0;
        while (lat < 40 && !got) begin
            @(posedge clk);
            #1;
            lat++;
            if (frame_valid) got = 1'b1;
        end
        tests_run++;
        if (!got || lat != STABLE + 3) begin
            fails++;
            $display("FAIL latency: got %0d cycles (seen=%0d) want %0d", lat, got, STABLE + 3);
        end
        tests_run++;
        if (hex_digits !== 16'h7965) begin fails++; $display("FAIL latency_hex: got %h want 7965", hex_digits); end
        @(posedge clk);
        #1;
        tests_run++;
        if (frame_valid !== 1'b0) begin fails++; $display("FAIL fv_pulse_width: got %b want 0", frame_valid); end
        show(4'hF, 8'hFF, 30);
        tests_run++;
        if (hex_digits !== 16'h7965) begin fails++; $display("FAIL hold_hex: got %h want 7965", hex_digits); end
    endtask

    task automatic test_toggle_stale();
        int fv0, de0;
        do_reset();
        fv0 = fv_total;
        de0 = de_total;
        for (int k = 0; k < 84; k++) show(4'b1110, seg(1 + (k % 2), 1'b0), 3);
        tests_run++;
        if (stale !== 1'b0) begin fails++; $display("FAIL stale_early: got %b want 0", stale); end
        for (int k = 0; k < 26; k++) show(4'b1110, seg(1 + (k % 2), 1'b0), 3);
        tests_run++;
        if (stale !== 1'b1) begin fails++; $display("FAIL stale_late: got %b want 1", stale); end
        tests_run++;
        if (fv_total - fv0 !== 0 || de_total - de0 !== 0) begin
            fails++;
            $display("FAIL toggle_nocap: got fv=%0d de=%0d want 0 0", fv_total - fv0, de_total - de0);
        end
        show(4'b1110, seg(3, 1'b0), 10);
        tests_run++;
        if (stale !== 1'b0) begin fails++; $display("FAIL stale_clear: got %b want 0", stale); end
    endtask

    task automatic test_decode_err();
        int fv0, de0;
        do_reset();
        fv0 = fv_total;
        de0 = de_total;
        show(an_of(0), seg(1, 1'b0), 10);
        show(an_of(1), seg(2, 1'b0), 10);
        show(an_of(2), 8'hFF, 10);
        show(an_of(3), seg(4, 1'b0), 10);
        show(4'hF, 8'hFF, 10);
        tests_run++;
        if (de_total - de0 !== 1) begin fails++; $display("FAIL decode_err_count: got %0d want 1", de_total - de0); end
        tests_run++;
        if (fv_total - fv0 !== 0) begin fails++; $display("FAIL decode_no_frame: got %0d want 0", fv_total - fv0); end
        show(an_of(2), seg(3, 1'b0), 10);
        show(4'hF, 8'hFF, 10);
        tests_run++;
        if (fv_total - fv0 !== 1 || hex_digits !== 16'h4321) begin
            fails++;
            $display("FAIL decode_recover: got %0d frames hex %h want 1 frame hex 4321", fv_total - fv0, hex_digits);
        end
    endtask

    task automatic test_two_low();
        int fv0, de0;
        do_reset();
        fv0 = fv_total;
        de0 = de_total;
        show(4'b1100, seg(5, 1'b0), 20);
        for (int i = 1; i < 4; i++) show(an_of(i), seg(i, 1'b0), 10);
        show(4'hF, 8'hFF, 10);
        tests_run++;
        if (fv_total - fv0 !== 0 || de_total - de0 !== 0) begin
            fails++;
            $display("FAIL two_low_nocap: got fv=%0d de=%0d want 0 0", fv_total - fv0, de_total - de0);
        end
        show(an_of(0), seg(14, 1'b0), 10);
        show(4'hF, 8'hFF, 10);
        tests_run++;
        if (fv_total - fv0 !== 1 || hex_digits !== 16'h321E) begin
            fails++;
            $display("FAIL two_low_complete: got %0d frames hex %h want 1 frame hex 321e", fv_total - fv0, hex_digits);
        end
    endtask

    task automatic test_reset_midframe();
        int fv0;
        do_reset();
        fv0 = fv_total;
        for (int i = 0; i < 3; i++) show(an_of(i), seg(10 + i, 1'b0), 10);
        do_reset();
        for (int i = 0; i < 4; i++) show(an_of(i), seg(10 + i, 1'b0), 10);
        show(4'hF, 8'hFF, 10);
        tests_run++;
        if (fv_total - fv0 !== 1) begin fails++; $display("FAIL midreset_count: got %0d want 1", fv_total - fv0); end
        tests_run++;
        if (hex_digits !== 16'hDCBA) begin fails++; $display("FAIL midreset_hex: got %h want dcba", hex_digits); end
    endtask

    task automatic test_all_eights();
        do_reset();
        for (int i = 0; i < 4; i++) show(an_of(i), 8'h00, 10);
        show(4'hF, 8'hFF, 10);
        tests_run++;
        if (hex_digits !== 16'h8888 || dp_bits !== 4'hF) begin
            fails++;
            $display("FAIL all_eights: got hex %h dp %b want 8888 1111", hex_digits, dp_bits);
        end
    endtask

    // Model: each maximal run of identical {an,sseg} with one digit low and length >= STABLE captures once.
    task automatic test_random(input int iter);
        logic [11:0] stim[$];
        logic [19:0] exp_q[$];
        logic [3:0]  nib [4];
        logic [3:0]  dpv, seen, a;
        logic [7:0]  g;
        logic [11:0] v;
        int exp_de, de0, len, kind, i, j, idx, hit;
        do_reset();
        frames_q.delete();
        de0 = de_total;
        for (int s = 0; s < 40; s++) begin
            len  = $urandom_range(1, 8);
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                case ($urandom_range(0, 3))
                    0: a = 4'hF;
                    1: a = 4'hC;
                    2: a = 4'h3;
                    default: a = 4'h0;
                endcase
                g = 8'($urandom);
            end else begin
                a = an_of($urandom_range(0, 3));
                if (kind < 8) g = seg($urandom_range(0, 15), 1'($urandom_range(0, 1)));
                else g = 8'($urandom);
            end
            repeat (len) stim.push_back({a, g});
        end
        repeat (20) stim.push_back(12'hFFF);

        for (int k = 0; k < 4; k++) nib[k] = 4'h0;
        dpv = 4'h0;
        seen = 4'h0;
        exp_de = 0;
        i = 0;
        while (i < stim.size()) begin
            j = i;
            while (j < stim.size() && stim[j] == stim[i]) j++;
            v = stim[i];
            if ($countones(~v[11:8]) == 1 && (j - i) >= STABLE) begin
                idx = 0;
                for (int k = 0; k < 4; k++) if (v[8 + k] == 1'b0) idx = k;
                hit = -1;
                for (int k = 0; k < 16; k++) if (glyph[k] == v[6:0]) hit = k;
                if (hit >= 0) begin
                    nib[idx]  = 4'(hit);
                    dpv[idx]  = ~v[7];
                    seen[idx] = 1'b1;
                    if (seen == 4'hF) begin
                        exp_q.push_back({dpv, nib[3], nib[2], nib[1], nib[0]});
                        seen = 4'h0;
                    end
                end else begin
                    exp_de++;
                    seen[idx] = 1'b0;
                end
            end
            i = j;
        end

        foreach (stim[k]) show(stim[k][11:8], stim[k][7:0], 1);

        tests_run++;
        if (frames_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL rand%0d_frames: got %0d frames want %0d", iter, frames_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                tests_run++;
                if (frames_q[k] !== exp_q[k]) begin
                    fails++;
                    $display("FAIL rand%0d_frame%0d: got %h want %h", iter, k, frames_q[k], exp_q[k]);
                end
            end
        end
        tests_run++;
        if (de_total - de0 !== exp_de) begin
            fails++;
            $display("FAIL rand%0d_decode_err: got %0d want %0d", iter, de_total - de0, exp_de);
        end
    endtask

    initial begin
        reset  = 1'b1;
        an_r   = 4'hF;
        sseg_r = 8'hFF;
        test_reset();
        test_basic_frame();
        test_latency();
        test_toggle_stale();
        test_decode_err();
        test_two_low();
        test_reset_midframe();
        test_all_eights();
        for (int r = 0; r < 4; r++) test_random(r);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/sseg_capture.md
SSEG_CAPTURE -- requirements
Module: sseg_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive identical synchronized samples required before a digit is captured (range 2..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 200000, is the number of cycles without a successful capture before stale asserts.
REQ-003 Port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port an, input, 4 bits: active-low digit enables from a multiplexed 7-segment driver.
REQ-006 Port sseg, input, 8 bits: active-low segments; bit 7 is dp; bits 6:0 are a,b,c,d,e,f,g.
REQ-007 Port hex_digits, output, 16 bits: last complete decoded frame; digit 0 is in bits 3:0.
REQ-008 Port dp_bits, output, 4 bits: captured dp per digit (1 = dp lit) for the same frame.
REQ-009 Port frame_valid, output, 1 bit: one-cycle pulse when hex_digits/dp_bits update.
REQ-010 Port decode_err, output, 1 bit: one-cycle pulse when a stable pattern matches no hex glyph.
REQ-011 Port stale, output, 1 bit: level; no successful capture within TIMEOUT_CYCLES.

Function
REQ-012 an and sseg pass through a two-flop synchronizer; all later references mean the synchronized values.
REQ-013 Glyph table for sseg[6:0], digits 0..F: 01,4F,12,06,4C,24,20,0F,00,04,08,60,31,42,30,38 (hex).
REQ-014 FSM states: WAIT, SETTLE, HELD.
REQ-015 WAIT: an not exactly one bit low; stability counter held at 0; on one-hot-low an go to SETTLE with counter = 1.
REQ-016 SETTLE: counter increments each cycle {an,sseg} equals the previous sample; any change restarts counter at 1 (non-one-hot an returns to WAIT).
REQ-017 Capture happens on the cycle counter reaches STABLE_CYCLES; FSM goes to HELD.
REQ-018 HELD: no re-capture; any change in {an,sseg} goes to SETTLE (or WAIT if an not one-hot).
REQ-019 Capture with a glyph match writes the nibble and dp into slot index of the low an bit, sets that slot's seen bit, clears the timeout counter.
REQ-020 Capture without a match pulses decode_err one cycle after the capture, clears that slot's seen bit, leaves the slot value unchanged, and does not clear the timeout counter.
REQ-021 Re-capture of an already-seen slot before frame completion overwrites its value; seen mask unchanged.
REQ-022 When the seen mask becomes 1111, the next cycle copies all four slots to hex_digits/dp_bits, pulses frame_valid, and clears the mask.
REQ-023 Latency: an/sseg pin change to frame_valid is 2 (sync) + STABLE_CYCLES + 1 cycles for the completing digit.
REQ-024 Timeout counter increments each cycle, saturating at TIMEOUT_CYCLES; stale = (counter == TIMEOUT_CYCLES); cleared the cycle after a successful capture.
REQ-025 hex_digits and dp_bits hold their value between frames.

Reset
REQ-026 On reset: FSM WAIT, synchronizer flops to all-ones (blank), counters 0, seen mask 0, slots 0.
REQ-027 On reset: hex_digits 0000, dp_bits 0000, frame_valid 0, decode_err 0, stale 0.
REQ-028 Reset mid-frame discards partial slots; no frame_valid is emitted for them.

Structure
REQ-029 Shared package sseg_pkg holds the 16-entry glyph table and FSM state encoding; hex_to_sseg remains the encoding source of truth and the table matches it bit-for-bit.
REQ-030 One sub-module, sseg_to_hex: combinational 7-bit pattern to {match, nibble}.

Verification
REQ-031 Drive digits 1,2,3,4 on an 1110,1101,1011,0111 for 10 cycles each -> one frame_valid, hex_digits 4321, dp_bits 0000.
REQ-032 Hold an=1110 with sseg toggling every 3 cycles (STABLE_CYCLES=4) -> no capture, no frame_valid, stale asserts after TIMEOUT_CYCLES.
REQ-033 Digit 2 pattern 7F (blank) on an=1011 -> decode_err pulse, no frame until digit 2 shows valid glyph.
REQ-034 an=1100 (two digits low) with valid glyph -> no capture.
REQ-035 Assert reset after three digits captured, then full frame A,B,C,D -> single frame_valid, hex_digits DCBA.
REQ-036 sseg=0x00 (dp lit, glyph 8) on all digits -> hex_digits 8888, dp_bits 1111.
